// File: rtl/muldiv_alu_sequencer.sv
// Iterative MUL / DIVU / REMU sequencer that borrows the shared EX-stage ALU
// for WIDTH cycles (shift-add multiply, restoring divide).
module muldiv_alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             alu_req,
  output logic [3:0]       alu_operation,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_MUL  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REMU = 2'd2;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // acc: product accumulator / partial remainder
  // opnd: shifting multiplicand / dividend-then-quotient
  // aux: shifting multiplier / divisor
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] aux_q, aux_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             accept;
  logic             last_iter;
  logic             is_mul;
  logic [WIDTH:0]   rs;
  logic             div_ge;
  logic [WIDTH-1:0] acc_nx;
  logic [WIDTH-1:0] opnd_nx;

  assign start_ready  = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign result_valid = (state_q == ST_DONE);
  assign result       = result_q;

  assign accept    = start_valid && (state_q == ST_IDLE) && !flush;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));
  assign is_mul    = (op_q == OP_MUL);

  // The ALU only sees WIDTH bits, so the restoring-divide compare uses the
  // full WIDTH+1-bit shifted remainder here; the subtraction still fits.
  assign rs     = {acc_q, opnd_q[WIDTH-1]};
  assign div_ge = (rs >= {1'b0, aux_q});

  always_comb begin
    alu_req       = 1'b0;
    alu_operation = ALU_ADD;
    alu_a         = '0;
    alu_b         = '0;
    if (state_q == ST_RUN) begin
      alu_req = 1'b1;
      if (is_mul) begin
        alu_operation = ALU_ADD;
        alu_a         = acc_q;
        alu_b         = aux_q[0] ? opnd_q : '0;
      end else begin
        alu_operation = ALU_SUB;
        alu_a         = rs[WIDTH-1:0];
        alu_b         = aux_q;
      end
    end
  end

  always_comb begin
    acc_nx  = acc_q;
    opnd_nx = opnd_q;
    if (is_mul) begin
      acc_nx  = alu_result;
      opnd_nx = opnd_q << 1;
    end else begin
      acc_nx  = div_ge ? alu_result : rs[WIDTH-1:0];
      opnd_nx = {opnd_q[WIDTH-2:0], div_ge};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    aux_d    = aux_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d   = op;
          cnt_d  = '0;
          acc_d  = '0;
          opnd_d = operand_a;
          aux_d  = operand_b;
          if (op == 2'b11) begin
            result_d = '0;
            state_d  = ST_DONE;
          end else if (op != OP_MUL && operand_b == '0) begin
            result_d = (op == OP_DIVU) ? {WIDTH{1'b1}} : operand_a;
            state_d  = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        cnt_d  = cnt_q + 1'b1;
        acc_d  = acc_nx;
        opnd_d = opnd_nx;
        if (is_mul) aux_d = aux_q >> 1;
        if (last_iter) begin
          state_d  = ST_DONE;
          result_d = (op_q == OP_DIVU) ? opnd_nx : acc_nx;
        end
      end
      ST_DONE: begin
        if (result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush && state_q != ST_IDLE) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      acc_q    <= '0;
      opnd_q   <= '0;
      aux_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      aux_q    <= aux_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_alu_sequencer.sv
// Randomized + directed bench for muldiv_alu_sequencer against an arithmetic reference.
module tb_muldiv_alu_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         result_valid;
  logic         result_ready = 1'b0;
  logic [W-1:0] result;
  logic         busy;
  logic         alu_req;
  logic [3:0]   alu_operation;
  logic [W-1:0] alu_a, alu_b, alu_result;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Shared EX-stage ALU stand-in
  assign alu_result = (alu_operation == 4'b0110) ? alu_a - alu_b :
                      (alu_operation == 4'b0010) ? alu_a + alu_b : '0;

  muldiv_alu_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .operand_a(operand_a), .operand_b(operand_b),
    .result_valid(result_valid), .result_ready(result_ready), .result(result),
    .busy(busy), .alu_req(alu_req), .alu_operation(alu_operation),
    .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_res(input logic [1:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0] r;
    case (o)
      2'd0: r = a * b;
      2'd1: r = (b == 0) ? {W{1'b1}} : a / b;
      2'd2: r = (b == 0) ? a : a % b;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold);
    logic [W-1:0] exp;
    logic [3:0]   eop;
    bit           short_path;
    int           lat, reqs, badop;
    exp        = ref_res(o, a, b);
    short_path = (o == 2'd3) || (o != 2'd0 && b == 0);
    eop        = (o == 2'd0) ? 4'b0010 : 4'b0110;
    @(negedge clk);
    op = o; operand_a = a; operand_b = b; start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat = 0; reqs = 0; badop = 0;
    while (!result_valid && lat <= W + 4) begin
      if (alu_req) begin
        reqs++;
        if (alu_operation !== eop) badop++;
      end
      // Garbage requests during RUN must be ignored
      start_valid = 1'($urandom_range(0, 1));
      op = 2'($urandom); operand_a = $urandom; operand_b = $urandom;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    start_valid = 1'b0;
    chk("latency", 64'(lat), short_path ? 64'd0 : 64'(W));
    chk("alu_req_cycles", 64'(reqs), short_path ? 64'd0 : 64'(W));
    chk("alu_op_in_run", 64'(badop), 64'd0);
    for (int i = 0; i < hold; i++) begin
      chk("hold_result", 64'(result), 64'(exp));
      chk("hold_flags", {61'd0, result_valid, busy, start_ready}, 64'b110);
      chk("hold_alu_idle", {59'd0, alu_req, alu_operation}, 64'h2);
      @(posedge clk);
      @(negedge clk);
    end
    chk("result", 64'(result), 64'(exp));
    chk("valid_before_hs", 64'(result_valid), 64'd1);
    result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    result_ready = 1'b0;
    chk("idle_after_hs", {61'd0, result_valid, busy, start_ready}, 64'b001);
  endtask

  task automatic flush_mid_run(input int iters);
    int seen;
    @(negedge clk);
    op = 2'd0; operand_a = $urandom; operand_b = $urandom; start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    for (int i = 1; i < iters; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("run_before_flush", {62'd0, busy, alu_req}, 64'b11);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle", {61'd0, result_valid, busy, start_ready}, 64'b001);
    seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (result_valid) seen++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("flush_no_result", 64'(seen), 64'd0);
  endtask

  initial begin
    #12;
    chk("rst_flags", {61'd0, result_valid, busy, alu_req}, 64'd0);
    chk("rst_alu", {alu_operation, alu_a, alu_b}, {4'b0010, 64'd0});
    chk("rst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("start_ready_after_rst", 64'(start_ready), 64'd1);

    run_op(2'd0, 32'd7, 32'd6, 0);
    run_op(2'd1, 32'd100, 32'd7, 1);
    run_op(2'd2, 32'd100, 32'd7, 0);
    run_op(2'd1, 32'd5, 32'd0, 0);
    run_op(2'd2, 32'd5, 32'd0, 2);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op(2'd2, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op(2'd3, 32'h1234_5678, 32'h9, 0);
    run_op(2'd0, 32'h0001_2345, 32'h0000_0ABC, 3);

    flush_mid_run(10);
    run_op(2'd1, 32'd1000, 32'd33, 0);

    // flush with a result waiting in DONE
    @(negedge clk);
    op = 2'd1; operand_a = 32'd9; operand_b = 32'd0; start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    chk("short_done", 64'(result_valid), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("flush_done_idle", {61'd0, result_valid, busy, start_ready}, 64'b001);

    // flush in IDLE wins over start
    flush = 1'b1; start_valid = 1'b1; op = 2'd0;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; start_valid = 1'b0;
    chk("flush_blocks_accept", {62'd0, busy, result_valid}, 64'd0);

    // async reset mid-RUN
    @(negedge clk);
    op = 2'd2; operand_a = $urandom; operand_b = 32'd13; start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_flags", {60'd0, result_valid, busy, alu_req, start_ready}, 64'b0001);
    chk("midrst_alu", {alu_operation, alu_a, alu_b}, {4'b0010, 64'd0});
    chk("midrst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'd2, 32'd100, 32'd7, 0);

    for (int n = 0; n < 24; n++) begin
      logic [1:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = 32'h8000_0000 | $urandom;
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
